// File: rtl/mealy_frame_rx.sv
// -----------------------------------------------------------------------------
// mealy_frame_rx
//   Parametrised Mealy serial frame receiver. While the strobe S is high, one
//   data bit D per clock is shifted into a WIDTH-bit word. The cycle in which S
//   returns low terminates the frame: R pulses for that one cycle together with
//   the trailer bit Y (= D) and an error flag, while Word/Len already hold the
//   complete payload. Frames longer than WIDTH park in OVF and discard bits.
//
// Parameters
//   WIDTH     : maximum payload bits per frame (2..32)
//   MIN_LEN   : minimum legal payload length (1..WIDTH)
//   LSB_FIRST : 0 = first bit ends up at the MSB of a full frame,
//               1 = first bit lands in Word[0]
//
// Ports
//   C      in   clock, rising edge
//   aR     in   asynchronous active-high reset
//   S      in   frame strobe
//   D      in   serial data
//   R      out  frame done (Mealy, terminating cycle only)
//   Y      out  trailer bit, D in the terminating cycle, else 0
//   Err    out  frame error, meaningful while R is high
//   Word   out  received payload (registered)
//   Len    out  number of bits received (registered, saturates at WIDTH)
//   StateQ out  current state code (IDLE=0, RECV=1, OVF=2)
// -----------------------------------------------------------------------------
module mealy_frame_rx #(
  parameter int WIDTH     = 8,
  parameter int MIN_LEN   = 1,
  parameter bit LSB_FIRST = 1'b0,
  localparam int LW       = $clog2(WIDTH + 1)
) (
  input  logic             C,
  input  logic             aR,
  input  logic             S,
  input  logic             D,
  output logic             R,
  output logic             Y,
  output logic             Err,
  output logic [WIDTH-1:0] Word,
  output logic [LW-1:0]    Len,
  output logic [1:0]       StateQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    OVF  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   word_q,  word_d;
  logic [LW-1:0]      len_q,   len_d;
  logic               r_s, y_s, err_s;

  // Insert one bit into the word according to the shift mode. In LSB-first mode
  // the bit goes to position len; upper bits were zeroed at frame start.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word,
                                                input logic [LW-1:0]    len,
                                                input logic             bit_in);
    logic [WIDTH-1:0] res;
    res = word;
    if (LSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (len == LW'(i)) begin
          res[i] = bit_in;
        end else begin
          res[i] = word[i];
        end
      end
    end else begin
      res = {word[WIDTH-2:0], bit_in};
    end
    return res;
  endfunction

  // Next-state, datapath update and Mealy outputs.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    r_s     = 1'b0;
    y_s     = 1'b0;
    err_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (S) begin
          // First bit always lands in bit 0, for both shift modes.
          word_d    = {WIDTH{1'b0}};
          word_d[0] = D;
          len_d     = LW'(1);
          state_d   = RECV;
        end else begin
          state_d = IDLE;
        end
      end
      RECV: begin
        if (S) begin
          if (len_q < LW'(WIDTH)) begin
            word_d  = shift_in(word_q, len_q, D);
            len_d   = len_q + LW'(1);
            state_d = RECV;
          end else begin
            // Word is full: keep it and swallow the rest of the frame.
            state_d = OVF;
          end
        end else begin
          r_s     = 1'b1;
          y_s     = D;
          err_s   = (len_q < LW'(MIN_LEN));
          state_d = IDLE;
        end
      end
      OVF: begin
        if (S) begin
          state_d = OVF;
        end else begin
          r_s     = 1'b1;
          y_s     = D;
          err_s   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        // Unused code 3: outputs quiet, fall back to IDLE.
        state_d = IDLE;
      end
    endcase
  end

  // State and payload registers with asynchronous reset.
  always_ff @(posedge C or posedge aR) begin
    if (aR) begin
      state_q <= IDLE;
      word_q  <= {WIDTH{1'b0}};
      len_q   <= {LW{1'b0}};
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
    end
  end

  assign R      = r_s;
  assign Y      = y_s;
  assign Err    = err_s;
  assign Word   = word_q;
  assign Len    = len_q;
  assign StateQ = state_q;

endmodule

// File: tb/tb_mealy_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_mealy_frame_rx
//   Directed self-checking bench. Two receivers share clock and reset: dut is
//   MSB-first with MIN_LEN=2, dut_l is LSB-first with MIN_LEN=2. Inputs change
//   1 time unit after the rising edge; outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_mealy_frame_rx;

  logic       C = 1'b0;
  logic       aR = 1'b1;
  logic       S = 1'b0, D = 1'b0;
  logic       S2 = 1'b0, D2 = 1'b0;
  logic       R, Y, Err;
  logic [7:0] Word;
  logic [3:0] Len;
  logic [1:0] StateQ;
  logic       RL, YL, ErrL;
  logic [7:0] WordL;
  logic [3:0] LenL;
  logic [1:0] StateQL;

  int errors = 0;
  int checks = 0;

  always #5 C = ~C;

  mealy_frame_rx #(.WIDTH(8), .MIN_LEN(2), .LSB_FIRST(1'b0)) dut (
    .C(C), .aR(aR), .S(S), .D(D), .R(R), .Y(Y), .Err(Err),
    .Word(Word), .Len(Len), .StateQ(StateQ)
  );

  mealy_frame_rx #(.WIDTH(8), .MIN_LEN(2), .LSB_FIRST(1'b1)) dut_l (
    .C(C), .aR(aR), .S(S2), .D(D2), .R(RL), .Y(YL), .Err(ErrL),
    .Word(WordL), .Len(LenL), .StateQ(StateQL)
  );

  // Apply inputs for one clock cycle; returns 1 unit after the next edge.
  task automatic cyc(input logic s, input logic d);
    S = s; D = d;
    @(posedge C); #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (StateQ !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", StateQ); end
    checks++; if (Word !== 8'h00) begin errors++; $display("FAIL rst_word got=%h exp=00", Word); end
    checks++; if (Len !== 4'd0) begin errors++; $display("FAIL rst_len got=%0d exp=0", Len); end
    checks++; if ({R, Y, Err} !== 3'b000) begin errors++; $display("FAIL rst_outs got=%b exp=000", {R, Y, Err}); end
    aR = 1'b0;
    @(posedge C); #1;
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
    checks++; if (Len !== 4'd3) begin errors++; $display("FAIL mid_len got=%0d exp=3", Len); end
    checks++; if (Y !== 1'b0) begin errors++; $display("FAIL mid_y got=%b exp=0", Y); end
    // Reset mid-frame, between clock edges.
    aR = 1'b1;
    #1;
    checks++; if (StateQ !== 2'd0) begin errors++; $display("FAIL arst_state got=%0d exp=0", StateQ); end
    checks++; if (Word !== 8'h00) begin errors++; $display("FAIL arst_word got=%h exp=00", Word); end
    checks++; if (Len !== 4'd0) begin errors++; $display("FAIL arst_len got=%0d exp=0", Len); end
    checks++; if (R !== 1'b0) begin errors++; $display("FAIL arst_r got=%b exp=0", R); end
    S = 1'b0; D = 1'b1;
    #1; aR = 1'b0;
    @(posedge C); #1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (R !== 1'b0) begin errors++; $display("FAIL post_rst_r cyc=%0d got=%b exp=0", i, R); end
      @(posedge C); #1;
    end
  endtask

  task automatic test_msb_frame;
    logic [7:0] bits;
    bits = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) cyc(1'b1, bits[i]);
    S = 1'b0; D = 1'b1; #1;
    checks++; if (R !== 1'b1) begin errors++; $display("FAIL msb_r got=%b exp=1", R); end
    checks++; if (Word !== 8'hB2) begin errors++; $display("FAIL msb_word got=%h exp=b2", Word); end
    checks++; if (Len !== 4'd8) begin errors++; $display("FAIL msb_len got=%0d exp=8", Len); end
    checks++; if (Y !== 1'b1) begin errors++; $display("FAIL msb_y got=%b exp=1", Y); end
    checks++; if (Err !== 1'b0) begin errors++; $display("FAIL msb_err got=%b exp=0", Err); end
    @(posedge C); #1;
    cyc(1'b0, 1'b1);
    checks++; if (StateQ !== 2'd0) begin errors++; $display("FAIL msb_idle got=%0d exp=0", StateQ); end
    checks++; if (R !== 1'b0) begin errors++; $display("FAIL msb_r_after got=%b exp=0", R); end
    checks++; if (Word !== 8'hB2) begin errors++; $display("FAIL msb_hold got=%h exp=b2", Word); end
  endtask

  task automatic test_short_frame;
    cyc(1'b1, 1'b1);
    S = 1'b0; D = 1'b0; #1;
    checks++; if (R !== 1'b1) begin errors++; $display("FAIL short_r got=%b exp=1", R); end
    checks++; if (Len !== 4'd1) begin errors++; $display("FAIL short_len got=%0d exp=1", Len); end
    checks++; if (Word !== 8'h01) begin errors++; $display("FAIL short_word got=%h exp=01", Word); end
    checks++; if (Y !== 1'b0) begin errors++; $display("FAIL short_y got=%b exp=0", Y); end
    checks++; if (Err !== 1'b1) begin errors++; $display("FAIL short_err got=%b exp=1", Err); end
    @(posedge C); #1;
    // Exactly MIN_LEN bits is legal.
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
    S = 1'b0; D = 1'b0; #1;
    checks++; if (Err !== 1'b0) begin errors++; $display("FAIL minlen_err got=%b exp=0", Err); end
    checks++; if (Word !== 8'h03) begin errors++; $display("FAIL minlen_word got=%h exp=03", Word); end
    @(posedge C); #1;
  endtask

  task automatic test_overflow;
    logic [10:0] bits;
    bits = 11'b1010_1010_111;
    for (int i = 10; i >= 3; i--) cyc(1'b1, bits[i]);
    checks++; if (StateQ !== 2'd1) begin errors++; $display("FAIL ovf_full_state got=%0d exp=1", StateQ); end
    for (int i = 2; i >= 0; i--) cyc(1'b1, bits[i]);
    checks++; if (StateQ !== 2'd2) begin errors++; $display("FAIL ovf_state got=%0d exp=2", StateQ); end
    checks++; if (Len !== 4'd8) begin errors++; $display("FAIL ovf_len got=%0d exp=8", Len); end
    checks++; if (Word !== 8'hAA) begin errors++; $display("FAIL ovf_word got=%h exp=aa", Word); end
    checks++; if (R !== 1'b0) begin errors++; $display("FAIL ovf_r_early got=%b exp=0", R); end
    S = 1'b0; D = 1'b1; #1;
    checks++; if ({R, Err, Y} !== 3'b111) begin errors++; $display("FAIL ovf_end got=%b exp=111", {R, Err, Y}); end
    @(posedge C); #1;
    checks++; if (StateQ !== 2'd0) begin errors++; $display("FAIL ovf_idle got=%0d exp=0", StateQ); end
  endtask

  task automatic test_back_to_back;
    logic s_v [8];
    logic d_v [8];
    int   pulses;
    s_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    d_v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      S = s_v[i]; D = d_v[i]; #1;
      if (R === 1'b1) pulses++;
      if (i == 3) begin
        checks++; if ({R, Word, Len} !== {1'b1, 8'h06, 4'd3}) begin errors++; $display("FAIL b2b_first got=%b/%h/%0d exp=1/06/3", R, Word, Len); end
      end
      if (i == 7) begin
        checks++; if ({R, Word, Len} !== {1'b1, 8'h03, 4'd3}) begin errors++; $display("FAIL b2b_second got=%b/%h/%0d exp=1/03/3", R, Word, Len); end
      end
      @(posedge C); #1;
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_lsb_first;
    logic [3:0] bits;
    bits = 4'b1001;
    for (int i = 3; i >= 0; i--) begin
      S2 = 1'b1; D2 = bits[i];
      @(posedge C); #1;
    end
    S2 = 1'b0; D2 = 1'b1; #1;
    checks++; if (WordL !== 8'h09) begin errors++; $display("FAIL lsb_word got=%h exp=09", WordL); end
    checks++; if (LenL !== 4'd4) begin errors++; $display("FAIL lsb_len got=%0d exp=4", LenL); end
    checks++; if ({RL, ErrL, YL} !== 3'b101) begin errors++; $display("FAIL lsb_outs got=%b exp=101", {RL, ErrL, YL}); end
    @(posedge C); #1;
    // Asymmetric pattern 1,1,0 -> bits 0,1 set.
    S2 = 1'b1; D2 = 1'b1; @(posedge C); #1;
    D2 = 1'b1; @(posedge C); #1;
    D2 = 1'b0; @(posedge C); #1;
    S2 = 1'b0; #1;
    checks++; if (WordL !== 8'h03) begin errors++; $display("FAIL lsb_word2 got=%h exp=03", WordL); end
    @(posedge C); #1;
    checks++; if (StateQL !== 2'd0) begin errors++; $display("FAIL lsb_idle got=%0d exp=0", StateQL); end
  endtask

  initial begin
    test_reset;
    test_msb_frame;
    test_short_frame;
    test_overflow;
    test_back_to_back;
    test_lsb_first;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
